uart_tx_ctrl: RTL and testbench

Frame sequencer for the UART transmitter. It accepts a byte request and drives the serializer load/shift strobes. It also steps the TX output mux select through the start, data, optional parity and stop phases, one bit per CLK cycle (CLK is the TX bit clock). It sits between the TX front end and the TX mux/serializer/parity-calc datapath.

---
 rtl/uart_tx_ctrl_if.sv | 28 ++
 rtl/uart_tx_ctrl.sv | 105 ++++++++++
 tb/tb_uart_tx_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// UART TX controller handshake bundle.
// Front end drives the request; controller drives datapath strobes.
interface uart_tx_ctrl_if;
  logic       data_valid;
  logic       par_en;
  logic       ser_load;
  logic       ser_shift;
  logic [1:0] mux_sel;
  logic       busy;

  modport master (
    output data_valid,
    output par_en,
    input  ser_load,
    input  ser_shift,
    input  mux_sel,
    input  busy
  );

  modport slave (
    input  data_valid,
    input  par_en,
    output ser_load,
    output ser_shift,
    output mux_sel,
    output busy
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start, data, optional parity, stop.
// One bit per CLK; drives serializer strobes and TX mux select.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input logic           CLK,
  input logic           RST,
  uart_tx_ctrl_if.slave tx
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] bit_cnt, bit_nxt;
  logic          stop_cnt, stop_nxt;
  logic          par_en_q, par_nxt;
  logic          accept;

  // State, counters and captured parity enable.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_nxt;
      stop_cnt <= stop_nxt;
      par_en_q <= par_nxt;
    end
  end

  // Next-state, Moore phase decode and Mealy load on acceptance.
  always_comb begin
    state_nxt    = state;
    bit_nxt      = bit_cnt;
    stop_nxt     = stop_cnt;
    par_nxt      = par_en_q;
    accept       = 1'b0;
    tx.mux_sel   = 2'b11;
    tx.busy      = 1'b0;
    tx.ser_shift = 1'b0;
    tx.ser_load  = 1'b0;
    case (state)
      IDLE: begin
        accept = tx.data_valid;
      end
      START: begin
        tx.mux_sel = 2'b00;
        tx.busy    = 1'b1;
        bit_nxt    = '0;
        state_nxt  = DATA;
      end
      DATA: begin
        tx.mux_sel   = 2'b01;
        tx.busy      = 1'b1;
        tx.ser_shift = 1'b1;
        if (bit_cnt == BIT_LAST) begin
          bit_nxt   = '0;
          state_nxt = par_en_q ? PARITY : STOP;
        end else begin
          bit_nxt = bit_cnt + 1'b1;
        end
      end
      PARITY: begin
        tx.mux_sel = 2'b10;
        tx.busy    = 1'b1;
        state_nxt  = STOP;
      end
      STOP: begin
        tx.busy = 1'b1;
        if (stop_cnt == STOP_LAST) begin
          stop_nxt  = 1'b0;
          state_nxt = IDLE;
          accept    = tx.data_valid;
        end else begin
          stop_nxt = stop_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        bit_nxt   = '0;
        stop_nxt  = 1'b0;
      end
    endcase
    if (accept) begin
      state_nxt = START;
      par_nxt   = tx.par_en;
    end
    tx.ser_load = accept && !RST;
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl.
// Two instances: 8 data/1 stop and 7 data/2 stop.
module tb_uart_tx_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic dv  = 1'b0;
  logic pe  = 1'b0;
  int   sel = 0;
  int   errors = 0;
  int   checks = 0;

  uart_tx_ctrl_if if8 ();
  uart_tx_ctrl_if if7 ();

  assign if8.data_valid = dv && (sel == 0);
  assign if8.par_en     = pe && (sel == 0);
  assign if7.data_valid = dv && (sel == 1);
  assign if7.par_en     = pe && (sel == 1);

  uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) u8 (
    .CLK(CLK),
    .RST(RST),
    .tx (if8.slave)
  );

  uart_tx_ctrl #(.DATA_WIDTH(7), .STOP_BITS(2)) u7 (
    .CLK(CLK),
    .RST(RST),
    .tx (if7.slave)
  );

  always #5 CLK = ~CLK;

  logic [1:0] mux;
  logic       busy, load, shift;

  always_comb begin
    if (sel == 0) begin
      mux   = if8.mux_sel;
      busy  = if8.busy;
      load  = if8.ser_load;
      shift = if8.ser_shift;
    end else begin
      mux   = if7.mux_sel;
      busy  = if7.busy;
      load  = if7.ser_load;
      shift = if7.ser_shift;
    end
  end

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cyc(input string tag, input logic [1:0] em,
                         input logic eb, input logic el, input logic es);
    chk({tag, ".mux"},   {2'b00, mux},   {2'b00, em});
    chk({tag, ".busy"},  {3'b000, busy},  {3'b000, eb});
    chk({tag, ".load"},  {3'b000, load},  {3'b000, el});
    chk({tag, ".shift"}, {3'b000, shift}, {3'b000, es});
  endtask

  task automatic step(input logic d, input logic p);
    @(negedge CLK);
    dv = d;
    pe = p;
    #1;
  endtask

  // Walks one frame after its accept cycle. mid_dv: request held in
  // start/data/parity; stop_dv: request in non-final stop cycles;
  // last_dv: request in final stop cycle (expects load then).
  task automatic run_frame(input string tag, input int dw, input int sb,
                           input logic par, input logic flip,
                           input logic mid_dv, input logic stop_dv,
                           input logic last_dv);
    int n;
    n = 1 + dw + int'(par) + sb;
    for (int i = 0; i < n; i++) begin
      logic [1:0] em;
      logic       d, p, lastc;
      if (i == 0)                    em = 2'b00;
      else if (i <= dw)              em = 2'b01;
      else if (par && i == dw + 1)   em = 2'b10;
      else                           em = 2'b11;
      lastc = (i == n - 1);
      if (lastc)           d = last_dv;
      else if (em == 2'b11) d = stop_dv;
      else                 d = mid_dv;
      p = (flip && em == 2'b01) ? ~par : par;
      step(d, p);
      chk_cyc($sformatf("%s[%0d]", tag, i), em, 1'b1,
              lastc && last_dv, em == 2'b01);
    end
  endtask

  initial begin
    // reset held, request must not load
    step(1'b1, 1'b0);
    chk_cyc("rst", 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    RST = 1'b0;
    step(1'b0, 1'b0);
    chk_cyc("idle0", 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk_cyc("idle1", 2'b11, 1'b0, 1'b0, 1'b0);

    // single frame, no parity
    step(1'b1, 1'b0);
    chk_cyc("f1.acc", 2'b11, 1'b0, 1'b1, 1'b0);
    run_frame("f1", 8, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk_cyc("f1.end", 2'b11, 1'b0, 1'b0, 1'b0);

    // parity frame, par_en dropped during data
    step(1'b1, 1'b1);
    chk_cyc("f2.acc", 2'b11, 1'b0, 1'b1, 1'b0);
    run_frame("f2", 8, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk_cyc("f2.end", 2'b11, 1'b0, 1'b0, 1'b0);

    // requests while busy are ignored
    step(1'b1, 1'b0);
    chk_cyc("f3.acc", 2'b11, 1'b0, 1'b1, 1'b0);
    run_frame("f3", 8, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk_cyc("f3.end", 2'b11, 1'b0, 1'b0, 1'b0);

    // back-to-back with data_valid held high
    step(1'b1, 1'b0);
    chk_cyc("f4.acc", 2'b11, 1'b0, 1'b1, 1'b0);
    run_frame("f4a", 8, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    run_frame("f4b", 8, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk_cyc("f4.end", 2'b11, 1'b0, 1'b0, 1'b0);

    // async reset mid-data at bit count 3
    step(1'b1, 1'b0);
    chk_cyc("f5.acc", 2'b11, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk_cyc("f5.start", 2'b00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0);
      chk_cyc($sformatf("f5.d%0d", i), 2'b01, 1'b1, 1'b0, 1'b1);
    end
    RST = 1'b1;
    #1;
    chk_cyc("f5.rst", 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      chk_cyc($sformatf("f5.idle%0d", i), 2'b11, 1'b0, 1'b0, 1'b0);
    end

    // 7 data bits, parity, 2 stop bits; first-stop request ignored,
    // second-stop request starts the next frame
    sel = 1;
    step(1'b0, 1'b0);
    chk_cyc("g.idle", 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk_cyc("g1.acc", 2'b11, 1'b0, 1'b1, 1'b0);
    run_frame("g1", 7, 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    run_frame("g2", 7, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk_cyc("g2.end", 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk_cyc("g2.idle", 2'b11, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
